conv_layer_sched: RTL
=====================

// Module: conv_layer_sched
// PURPOSE
//  Layer-level sequencer for conv_top. Per layer: loads biases once, then walks output-channel
//  groups 0..cfg_co_groups-1. Per group: weight load (if needed), group/base-address programming,
//  and a go pulse to conv_top in lock-step with the input/output DMA starts.
//  Sits between the CPU-side layer registers and conv_top, its weight/bias DMAs, and its pixel DMAs.
// PARAMETERS
//  WT_DEPTH         4096     conv_top weight memory depth (words, one word per ci-group)
//  WT_ADDR_WIDTH    12       $clog2(WT_DEPTH)
//  BIAS_GROUP_BITS  7        width of conv_top output-group index
//  TIMEOUT_CYCLES   2**24    watchdog limit for any single wait state
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    reset, synchronous, active-high
//  start               in   1    begin layer; ignored while busy
//  cfg_ci_groups       in   10   input-channel groups (8 ch each); sampled at start
//  cfg_co_groups       in   8    output-channel groups (8 ch each), 1..2**BIAS_GROUP_BITS; sampled at start
//  busy                out  1    high from cycle after accepted start until done
//  done                out  1    1-cycle pulse at layer end (normal or error)
//  error               out  1    sticky error flag; cleared by next accepted start
//  bias_wr_addr_rst    out  1    1-cycle pulse; rewinds bias write pointer
//  bias_dma_req        out  1    1-cycle pulse; request whole-layer bias DMA
//  bias_dma_done       in   1    bias DMA finished
//  wt_wr_addr_rst      out  1    1-cycle pulse; rewinds weight write pointer
//  wt_dma_req          out  1    1-cycle pulse; request weight DMA
//  wt_dma_first_group  out  8    first output group to fetch (valid with req)
//  wt_dma_num_groups   out  8    number of groups to fetch (valid with req)
//  wt_dma_done         in   1    weight DMA finished
//  ct_output_group     out  BIAS_GROUP_BITS  conv_top cfg_output_group
//  ct_wt_base_addr     out  WT_ADDR_WIDTH    conv_top cfg_wt_base_addr
//  ct_go               out  1    1-cycle go pulse to conv_top
//  ct_done             in   1    conv_top done pulse
//  in_dma_start        out  1    1-cycle pulse; replay full input tensor
//  out_dma_start       out  1    1-cycle pulse; arm output DMA
//  out_dma_group       out  8    output group index for output DMA addressing
//  out_dma_done        in   1    output DMA drained
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; group counter and base-address accumulator 0.
//  rst mid-operation aborts immediately, with no done pulse.
//  FSM: IDLE -> CHECK -> BIAS_LD -> WT_LD -> LAUNCH -> RUN -> ADV -> (WT_LD | FINISH) -> IDLE.
//  IDLE
//   - start latches cfg_* and clears error. busy rises on the next cycle.
//  CHECK (1 cycle)
//   - ci_groups==0 or co_groups==0: set error, go to FINISH.
//   - Else register resident = (co_groups*ci_groups <= WT_DEPTH).
//   - Pulse bias_wr_addr_rst and bias_dma_req, then go to BIAS_LD.
//  BIAS_LD
//   - Wait for bias_dma_done, then go to WT_LD.
//  WT_LD
//   - Load needed if !resident, or if resident and g==0.
//   - If needed: pulse wt_wr_addr_rst and wt_dma_req.
//     first_group = g; num_groups = resident ? co_groups : 1. Wait for wt_dma_done.
//   - Otherwise go to LAUNCH on the next cycle.
//  LAUNCH (1 cycle)
//   - ct_output_group = g. ct_wt_base_addr = resident ? base_acc : 0.
//   - Both are registered and stable at least 1 cycle before ct_go, and held through RUN.
//   - ct_go, in_dma_start, out_dma_start pulse together; out_dma_group = g.
//  RUN
//   - Sticky flags record ct_done and out_dma_done; arrival in any order or the same cycle is legal.
//   - Leave RUN the cycle after both flags are set; flags clear on exit.
//  ADV (1 cycle)
//   - If g == co_groups-1, go to FINISH.
//   - Else g += 1, base_acc += ci_groups (adder only, no multiplier), go to WT_LD.
//  FINISH
//   - done = 1 for 1 cycle, busy drops the same cycle, then IDLE.
//  Watchdog
//   - Counter clears on every state entry and increments in BIAS_LD, WT_LD (waiting) and RUN.
//   - Reaching TIMEOUT_CYCLES sets error and goes to FINISH.
//  Done inputs arriving outside their wait state are ignored.
//  start while busy has no effect.
// STRUCTURE
//  conv_pkg: sched_state_t enum (IDLE, CHECK, BIAS_LD, WT_LD, LAUNCH, RUN, ADV, FINISH)
//  and the default TIMEOUT_CYCLES constant.
//  Sub-module conv_sched_watchdog: loadable counter (clr, en, limit) -> expired.
//  FSM and counters live in conv_layer_sched.
// TESTING
//  - ci=4, co=3 (resident): exactly one wt_dma_req (first=0, num=3). ct_wt_base_addr = 0, 4, 8.
//    3 ct_go pulses; one done; error=0.
//  - ci=600, co=8 (4800 > 4096): 8 wt_dma_req (num=1, first=g), each preceded by wt_wr_addr_rst.
//    ct_wt_base_addr = 0 every group.
//  - out_dma_done 5 cycles after ct_done, and same-cycle variant: next WT_LD/ADV entered exactly
//    1 cycle after the later event.
//  - co=0: done pulses 2 cycles after start; error=1; no DMA requests and no ct_go.
//  - Withhold ct_done with TIMEOUT_CYCLES=100: error=1 and done 100 cycles after RUN entry.
//    Next start clears error.
//  - rst asserted in RUN: all outputs 0 next cycle, no done. start pulsed while busy is ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv_top layer sequencer.
package conv_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 2**24;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BIAS_LD,
        WT_LD,
        LAUNCH,
        RUN,
        ADV,
        FINISH
    } sched_state_t;

endpackage

// File: rtl/conv_sched_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle whose increment would reach the limit.
module conv_sched_watchdog #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Asserted on the limit-th waiting cycle so the owner leaves exactly then.
    assign expired = en && (r_count == (limit - WIDTH'(1)));

endmodule

// File: rtl/conv_layer_sched.sv
// Layer-level sequencer for conv_top: bias load, then per output-channel group
// weight load, address programming and a go pulse in step with the pixel DMAs.
module conv_layer_sched
    import conv_pkg::*;
#(
    parameter int WT_DEPTH        = 4096,
    parameter int WT_ADDR_WIDTH   = $clog2(WT_DEPTH),
    parameter int BIAS_GROUP_BITS = 7,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [9:0]                 cfg_ci_groups,
    input  logic [7:0]                 cfg_co_groups,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       bias_wr_addr_rst,
    output logic                       bias_dma_req,
    input  logic                       bias_dma_done,
    output logic                       wt_wr_addr_rst,
    output logic                       wt_dma_req,
    output logic [7:0]                 wt_dma_first_group,
    output logic [7:0]                 wt_dma_num_groups,
    input  logic                       wt_dma_done,
    output logic [BIAS_GROUP_BITS-1:0] ct_output_group,
    output logic [WT_ADDR_WIDTH-1:0]   ct_wt_base_addr,
    output logic                       ct_go,
    input  logic                       ct_done,
    output logic                       in_dma_start,
    output logic                       out_dma_start,
    output logic [7:0]                 out_dma_group,
    input  logic                       out_dma_done
);

    localparam int          WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [17:0] LP_DEPTH = 18'(WT_DEPTH);

    sched_state_t             r_state;
    sched_state_t             w_next;
    logic [9:0]               r_ci;
    logic [7:0]               r_co;
    logic                     r_resident;
    logic                     r_error;
    logic [7:0]               r_g;
    logic [WT_ADDR_WIDTH-1:0] r_base_acc;
    logic [WT_ADDR_WIDTH-1:0] r_ct_base;
    logic                     r_wt_issued;
    logic                     r_ct_seen;
    logic                     r_out_seen;

    logic                     w_wt_needed;
    logic                     w_wt_req;
    logic                     w_bias_req;
    logic                     w_launch;
    logic                     w_set_error;
    logic                     w_both_done;
    logic                     w_wd_en;
    logic                     w_wd_clr;
    logic                     w_wd_expired;
    logic [17:0]              w_product;
    logic [WT_ADDR_WIDTH-1:0] w_base_nxt;

    assign w_product  = {10'd0, r_co} * {8'd0, r_ci};
    assign w_base_nxt = r_base_acc + WT_ADDR_WIDTH'(r_ci);
    assign w_wd_en    = (r_state == BIAS_LD) || (r_state == RUN) ||
                        ((r_state == WT_LD) && r_wt_issued);
    assign w_wd_clr   = (w_next != r_state);

    conv_sched_watchdog #(
        .WIDTH (WDOG_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .limit   (WDOG_W'(TIMEOUT_CYCLES)),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Done inputs take priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_wt_needed = !r_resident || (r_g == 8'd0);
        w_wt_req    = 1'b0;
        w_bias_req  = 1'b0;
        w_launch    = 1'b0;
        w_set_error = 1'b0;
        w_both_done = (r_ct_seen || ct_done) && (r_out_seen || out_dma_done);
        case (r_state)
            IDLE: begin
                if (start) w_next = CHECK;
            end
            CHECK: begin
                if ((r_ci == 10'd0) || (r_co == 8'd0)) begin
                    w_set_error = 1'b1;
                    w_next      = FINISH;
                end else begin
                    w_bias_req = 1'b1;
                    w_next     = BIAS_LD;
                end
            end
            BIAS_LD: begin
                if (bias_dma_done) begin
                    w_next = WT_LD;
                end else if (w_wd_expired) begin
                    w_set_error = 1'b1;
                    w_next      = FINISH;
                end
            end
            WT_LD: begin
                if (!w_wt_needed) begin
                    w_next = LAUNCH;
                end else if (!r_wt_issued) begin
                    w_wt_req = 1'b1;
                end else if (wt_dma_done) begin
                    w_next = LAUNCH;
                end else if (w_wd_expired) begin
                    w_set_error = 1'b1;
                    w_next      = FINISH;
                end
            end
            LAUNCH: begin
                w_launch = 1'b1;
                w_next   = RUN;
            end
            RUN: begin
                if (w_both_done) begin
                    w_next = ADV;
                end else if (w_wd_expired) begin
                    w_set_error = 1'b1;
                    w_next      = FINISH;
                end
            end
            ADV: begin
                w_next = (r_g == (r_co - 8'd1)) ? FINISH : WT_LD;
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Group index and base address move only in CHECK/ADV, so conv_top sees
    // them settled through WT_LD before the go pulse and held through RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ci        <= '0;
            r_co        <= '0;
            r_resident  <= 1'b0;
            r_error     <= 1'b0;
            r_g         <= '0;
            r_base_acc  <= '0;
            r_ct_base   <= '0;
            r_wt_issued <= 1'b0;
            r_ct_seen   <= 1'b0;
            r_out_seen  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_ci    <= cfg_ci_groups;
                r_co    <= cfg_co_groups;
                r_error <= 1'b0;
            end
            if (w_set_error) r_error <= 1'b1;
            if (r_state == CHECK) begin
                r_resident <= (w_product <= LP_DEPTH);
                r_g        <= '0;
                r_base_acc <= '0;
                r_ct_base  <= '0;
            end
            if ((r_state == ADV) && (w_next == WT_LD)) begin
                r_g        <= r_g + 8'd1;
                r_base_acc <= w_base_nxt;
                r_ct_base  <= r_resident ? w_base_nxt : '0;
            end
            r_wt_issued <= (r_state == WT_LD) && (w_next == WT_LD) && (r_wt_issued || w_wt_req);
            r_ct_seen   <= (r_state == RUN) && (w_next == RUN) && (r_ct_seen || ct_done);
            r_out_seen  <= (r_state == RUN) && (w_next == RUN) && (r_out_seen || out_dma_done);
        end
    end

    assign busy               = (r_state != IDLE) && (r_state != FINISH);
    assign done               = (r_state == FINISH);
    assign error              = r_error;
    assign bias_wr_addr_rst   = w_bias_req;
    assign bias_dma_req       = w_bias_req;
    assign wt_wr_addr_rst     = w_wt_req;
    assign wt_dma_req         = w_wt_req;
    assign wt_dma_first_group = w_wt_req ? r_g : 8'd0;
    assign wt_dma_num_groups  = w_wt_req ? (r_resident ? r_co : 8'd1) : 8'd0;
    assign ct_output_group    = r_g[BIAS_GROUP_BITS-1:0];
    assign ct_wt_base_addr    = r_ct_base;
    assign ct_go              = w_launch;
    assign in_dma_start       = w_launch;
    assign out_dma_start      = w_launch;
    assign out_dma_group      = r_g;

endmodule
